// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: loads and stores over a req/ack data bus.
// Handles lane steering, extension, alignment checks and bus timeout, and stalls while busy.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_reg_waddr,
    input  logic        ex_we,
    input  logic [31:0] ex_reg_wdata,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_store_data,
    input  logic [5:0]  stall,
    output logic [4:0]  mem_reg_waddr,
    output logic        mem_we,
    output logic [31:0] mem_reg_wdata,
    output logic [1:0]  mem_exc,
    output logic        stallreq,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     rdata_q;
    logic [1:0]      exc_q;

    logic            memop, illegal, misaligned, start, timeout_hit;
    logic [1:0]      a;
    logic [3:0]      lane_be;
    logic [31:0]     lane_wdata;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     load_data;
    logic            unused_stall;

    assign unused_stall = ^{stall[5], stall[3:0]};

    assign memop = ex_is_load | ex_is_store;
    assign a     = ex_reg_wdata[1:0];

    always_comb begin
        illegal = 1'b0;
        unique case (ex_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = ex_is_store;
            default:                illegal = 1'b1;
        endcase
        illegal    = memop & illegal;
        misaligned = memop & ~illegal &
                     (((ex_funct3[1:0] == 2'b01) & a[0]) |
                      ((ex_funct3 == 3'b010) & (a != 2'b00)));
    end

    assign start       = (state_q == StIdle) & memop & ~illegal & ~misaligned;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutLast);

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = ex_store_data;
        unique case (ex_funct3[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << a;
                lane_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                lane_be    = a[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StWait;
            StWait:  if (dbus_ack || timeout_hit) state_d = StDone;
            StDone:  if (!stall[4]) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus fields stay frozen for the whole WAIT; only req drops when the access ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'h0;
            dbus_be    <= 4'h0;
            dbus_wdata <= 32'h0;
            rdata_q    <= 32'h0;
            cnt_q      <= '0;
            exc_q      <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= ex_is_store;
                        dbus_addr  <= {ex_reg_wdata[31:2], 2'b00};
                        dbus_be    <= lane_be;
                        dbus_wdata <= lane_wdata;
                        cnt_q      <= '0;
                        exc_q      <= 2'b00;
                    end
                end
                StWait: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        rdata_q  <= dbus_rdata;
                    end else if (timeout_hit) begin
                        dbus_req <= 1'b0;
                        exc_q    <= 2'b10;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_sel = rdata_q[{a, 3'b000} +: 8];
    assign half_sel = a[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        unique case (ex_funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = rdata_q;
        endcase
    end

    always_comb begin
        mem_reg_waddr = ex_reg_waddr;
        mem_reg_wdata = ex_reg_wdata;
        mem_we        = 1'b0;
        mem_exc       = 2'b00;
        stallreq      = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (!memop)          mem_we   = ex_we;
                    else if (illegal)    mem_exc  = 2'b11;
                    else if (misaligned) mem_exc  = 2'b01;
                    else                 stallreq = 1'b1;
                end
                StWait: stallreq = 1'b1;
                StDone: begin
                    mem_exc = exc_q;
                    mem_we  = (exc_q == 2'b10) ? 1'b0 : ex_we;
                    if (ex_is_load) mem_reg_wdata = load_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM/WB results are queued when an
// instruction is presented and compared when the stage produces its result.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_reg_waddr;
    logic        ex_we;
    logic [31:0] ex_reg_wdata;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_store_data;
    logic [5:0]  stall;
    logic [4:0]  mem_reg_waddr;
    logic        mem_we;
    logic [31:0] mem_reg_wdata;
    logic [1:0]  mem_exc;
    logic        stallreq;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_reg_waddr  (ex_reg_waddr),
        .ex_we         (ex_we),
        .ex_reg_wdata  (ex_reg_wdata),
        .ex_is_load    (ex_is_load),
        .ex_is_store   (ex_is_store),
        .ex_funct3     (ex_funct3),
        .ex_store_data (ex_store_data),
        .stall         (stall),
        .mem_reg_waddr (mem_reg_waddr),
        .mem_we        (mem_we),
        .mem_reg_wdata (mem_reg_wdata),
        .mem_exc       (mem_exc),
        .stallreq      (stallreq),
        .dbus_req      (dbus_req),
        .dbus_we       (dbus_we),
        .dbus_addr     (dbus_addr),
        .dbus_be       (dbus_be),
        .dbus_wdata    (dbus_wdata),
        .dbus_rdata    (dbus_rdata),
        .dbus_ack      (dbus_ack)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        we;
        logic [1:0]  exc;
        logic        chk_data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        ex_is_load    = 1'b0;
        ex_is_store   = 1'b0;
        ex_we         = 1'b0;
        ex_funct3     = 3'b000;
        ex_reg_waddr  = 5'd0;
        ex_reg_wdata  = 32'h0;
        ex_store_data = 32'h0;
        stall         = 6'b0;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic we, input logic [4:0] waddr);
        ex_is_load    = ld;
        ex_is_store   = st;
        ex_funct3     = f3;
        ex_reg_wdata  = addr;
        ex_store_data = sdata;
        ex_we         = we;
        ex_reg_waddr  = waddr;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        check({tag, ".sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (e.chk_data) check({tag, ".wdata"}, mem_reg_wdata, e.data);
            check({tag, ".we"}, 32'(mem_we), 32'(e.we));
            check({tag, ".exc"}, 32'(mem_exc), 32'(e.exc));
        end
    endtask

    // Runs one valid memop; ack_delay = extra WAIT cycles before ack, negative = never ack.
    task automatic run_mem(input string tag, input logic ld, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic we, input int ack_delay, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input exp_t exp_res, input int exp_stall, input int hold);
        int n_stall = 0;
        int n_req   = 0;
        logic done  = 1'b0;
        drive(ld, !ld, f3, addr, sdata, we, 5'd7);
        sb_q.push_back(exp_res);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            dbus_ack   = 1'b0;
            dbus_rdata = $urandom;
            if (!stallreq) begin
                done = 1'b1;
            end else begin
                n_stall++;
                if (dbus_req) begin
                    check({tag, ".addr"}, dbus_addr, {addr[31:2], 2'b00});
                    check({tag, ".bus_we"}, 32'(dbus_we), 32'(!ld));
                    if (!ld) begin
                        check({tag, ".be"}, 32'(dbus_be), 32'(exp_be));
                        check({tag, ".bus_wdata"}, dbus_wdata, exp_wdata);
                    end
                    if (n_req == ack_delay) begin
                        dbus_ack   = 1'b1;
                        dbus_rdata = rdata;
                    end
                    n_req++;
                end
            end
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        compare_out(tag);
        check({tag, ".stall_cycles"}, n_stall, exp_stall);
        check({tag, ".req_cycles"}, n_req, exp_stall - 1);
        if (hold > 0) begin
            stall = 6'b010000;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check({tag, ".hold_stallreq"}, 32'(stallreq), 32'd0);
                check({tag, ".hold_req"}, 32'(dbus_req), 32'd0);
                if (exp_res.chk_data) check({tag, ".hold_wdata"}, mem_reg_wdata, exp_res.data);
            end
            stall = 6'b0;
        end
        @(posedge clk);
        #1;
        set_idle();
        @(negedge clk);
        check({tag, ".idle_stallreq"}, 32'(stallreq), 32'd0);
        check({tag, ".idle_req"}, 32'(dbus_req), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_exc(input string tag, input logic ld, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [1:0] exc);
        drive(ld, !ld, f3, addr, 32'h1111_2222, 1'b1, 5'd9);
        sb_q.push_back('{data: 32'h0, we: 1'b0, exc: exc, chk_data: 1'b0});
        @(negedge clk);
        compare_out(tag);
        check({tag, ".stallreq"}, 32'(stallreq), 32'd0);
        @(negedge clk);
        check({tag, ".no_req"}, 32'(dbus_req), 32'd0);
        @(posedge clk);
        #1;
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        dbus_ack   = 1'b0;
        dbus_rdata = 32'h0;
        set_idle();
        drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 5'd3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.stallreq", 32'(stallreq), 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_exc", 32'(mem_exc), 32'd0);
        check("rst.req", 32'(dbus_req), 32'd0);
        check("rst.be", 32'(dbus_be), 32'd0);
        check("rst.addr", dbus_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle();

        // ALU op passes straight through
        drive(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 1'b1, 5'd5);
        sb_q.push_back('{data: 32'h1234, we: 1'b1, exc: 2'b00, chk_data: 1'b1});
        @(negedge clk);
        compare_out("alu");
        check("alu.waddr", 32'(mem_reg_waddr), 32'd5);
        check("alu.stallreq", 32'(stallreq), 32'd0);
        check("alu.req", 32'(dbus_req), 32'd0);
        @(negedge clk);
        check("alu.req_next", 32'(dbus_req), 32'd0);
        @(posedge clk);
        #1;
        set_idle();

        run_mem("lb", 1'b1, 3'b000, 32'h103, 32'h0, 1'b1, 0, 32'h80FF_FF7F, 4'h0, 32'h0,
                '{data: 32'hFFFF_FF80, we: 1'b1, exc: 2'b00, chk_data: 1'b1}, 2, 0);
        run_mem("lbu", 1'b1, 3'b100, 32'h103, 32'h0, 1'b1, 0, 32'h80FF_FF7F, 4'h0, 32'h0,
                '{data: 32'h0000_0080, we: 1'b1, exc: 2'b00, chk_data: 1'b1}, 2, 2);
        run_mem("lh", 1'b1, 3'b001, 32'h102, 32'h0, 1'b1, 1, 32'h8001_1234, 4'h0, 32'h0,
                '{data: 32'hFFFF_8001, we: 1'b1, exc: 2'b00, chk_data: 1'b1}, 3, 0);
        run_mem("lhu", 1'b1, 3'b101, 32'h100, 32'h0, 1'b1, 0, 32'h8001_9234, 4'h0, 32'h0,
                '{data: 32'h0000_9234, we: 1'b1, exc: 2'b00, chk_data: 1'b1}, 2, 0);
        run_mem("sh", 1'b0, 3'b001, 32'h202, 32'hAAAA_BEEF, 1'b0, 3, 32'h0, 4'b1100,
                32'hBEEF_BEEF, '{data: 32'h0, we: 1'b0, exc: 2'b00, chk_data: 1'b0}, 5, 0);
        run_mem("sb", 1'b0, 3'b000, 32'h301, 32'h1234_565A, 1'b0, 0, 32'h0, 4'b0010,
                32'h5A5A_5A5A, '{data: 32'h0, we: 1'b0, exc: 2'b00, chk_data: 1'b0}, 2, 0);
        run_mem("sw", 1'b0, 3'b010, 32'h400, 32'hCAFE_F00D, 1'b0, 1, 32'h0, 4'b1111,
                32'hCAFE_F00D, '{data: 32'h0, we: 1'b0, exc: 2'b00, chk_data: 1'b0}, 3, 0);

        run_exc("lw_mis", 1'b1, 3'b010, 32'h6, 2'b01);
        run_exc("lh_mis", 1'b1, 3'b001, 32'h101, 2'b01);
        run_exc("ld_f3_011", 1'b1, 3'b011, 32'h40, 2'b11);
        run_exc("st_f3_100", 1'b0, 3'b100, 32'h40, 2'b11);

        run_mem("timeout", 1'b1, 3'b010, 32'h80, 32'h0, 1'b1, -1, 32'h0, 4'h0, 32'h0,
                '{data: 32'h0, we: 1'b0, exc: 2'b10, chk_data: 1'b0}, 5, 0);

        // Reset while the access is waiting for ack
        drive(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 1'b1, 5'd4);
        @(negedge clk);
        check("rstwait.idle_stallreq", 32'(stallreq), 32'd1);
        @(negedge clk);
        check("rstwait.req_up", 32'(dbus_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstwait.req_drop", 32'(dbus_req), 32'd0);
        check("rstwait.stallreq", 32'(stallreq), 32'd0);
        rst = 1'b0;
        set_idle();
        @(negedge clk);
        check("rstwait.after_stallreq", 32'(stallreq), 32'd0);
        @(posedge clk);
        #1;
        run_mem("lw_after_rst", 1'b1, 3'b010, 32'h40, 32'h0, 1'b1, 0, 32'hDEAD_BEEF, 4'h0,
                32'h0, '{data: 32'hDEAD_BEEF, we: 1'b1, exc: 2'b00, chk_data: 1'b1}, 2, 0);

        check("sb.drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
